// File: rtl/riscv_alu_pkg.sv
// Shared definitions for the ALU arbiter and the decode stage: op codes,
// strobe width and the arbiter state encoding.
package riscv_alu_pkg;

  localparam logic [3:0] ALU_OP_ADD  = 4'd0;
  localparam logic [3:0] ALU_OP_SUB  = 4'd1;
  localparam logic [3:0] ALU_OP_OR   = 4'd2;
  localparam logic [3:0] ALU_OP_XOR  = 4'd3;
  localparam logic [3:0] ALU_OP_AND  = 4'd4;
  localparam logic [3:0] ALU_OP_SLL  = 4'd5;
  localparam logic [3:0] ALU_OP_SRL  = 4'd6;
  localparam logic [3:0] ALU_OP_SRA  = 4'd7;
  localparam logic [3:0] ALU_OP_SLTU = 4'd8;
  localparam logic [3:0] ALU_OP_SLT  = 4'd9;

  localparam int ALU_SEL_W = 10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/riscv_alu_op_decode.sv
// Op code to one-hot ALU strobe decode; codes outside 0..9 give no strobe
// and raise the illegal flag.
module riscv_alu_op_decode
  import riscv_alu_pkg::*;
(
  input  logic [3:0]           op,
  output logic [ALU_SEL_W-1:0] sel,
  output logic                 illegal
);

  always_comb begin
    sel     = '0;
    illegal = 1'b0;
    case (op)
      ALU_OP_ADD:  sel[0] = 1'b1;
      ALU_OP_SUB:  sel[1] = 1'b1;
      ALU_OP_OR:   sel[2] = 1'b1;
      ALU_OP_XOR:  sel[3] = 1'b1;
      ALU_OP_AND:  sel[4] = 1'b1;
      ALU_OP_SLL:  sel[5] = 1'b1;
      ALU_OP_SRL:  sel[6] = 1'b1;
      ALU_OP_SRA:  sel[7] = 1'b1;
      ALU_OP_SLTU: sel[8] = 1'b1;
      ALU_OP_SLT:  sel[9] = 1'b1;
      default:     illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_alu_arbiter.sv
// Shares one registered-output ALU between NREQ requesters with a valid/ready
// request and response channel. RISCV_ALU_ARB_RR_EN selects round-robin grant.
module riscv_alu_arbiter
  import riscv_alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int XLEN = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [4*NREQ-1:0]        req_op,
  input  logic [XLEN*NREQ-1:0]     req_a,
  input  logic [XLEN*NREQ-1:0]     req_b,
  output logic [XLEN-1:0]          alu_a,
  output logic [XLEN-1:0]          alu_b,
  output logic [ALU_SEL_W-1:0]     alu_sel,
  input  logic [XLEN-1:0]          alu_result,
  output logic                     rsp_valid,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [XLEN-1:0]          rsp_data,
  input  logic                     rsp_ready
);

  localparam int ID_W = $clog2(NREQ);

  arb_state_t            state;
  logic                  grant_any;
  logic [ID_W-1:0]       grant_id;
  logic                  can_accept;
  logic                  accept;
  logic [3:0]            sel_op;
  logic [ALU_SEL_W-1:0]  sel_dec;
  logic                  illegal_dec;
  logic                  illegal_p0;
  logic [ID_W-1:0]       id_p0;

`ifdef RISCV_ALU_ARB_RR_EN
  // Holds the index where the next search starts, i.e. last grant + 1.
  logic [ID_W-1:0]       ptr;

  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_any && req_valid[(int'(ptr) + k) % NREQ]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'((int'(ptr) + k) % NREQ);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end
`else
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'(i);
      end
    end
  end
`endif

  // A new request may enter from IDLE, or from RESP in the cycle the response drains.
  assign can_accept = (state == S_IDLE) || ((state == S_RESP) && rsp_ready);
  assign accept     = rst && can_accept && grant_any;
  assign sel_op     = req_op[4*grant_id +: 4];

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_id] = 1'b1;
  end

  riscv_alu_op_decode u_op_decode (
    .op      (sel_op),
    .sel     (sel_dec),
    .illegal (illegal_dec)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      illegal_p0 <= 1'b0;
      id_p0      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
    end else begin
      case (state)
        S_IDLE:  if (accept) state <= S_ISSUE;
        S_ISSUE: state <= S_WAIT;
        // ALU output is valid during WAIT; capture it and release the strobes.
        S_WAIT: begin
          alu_sel   <= '0;
          rsp_data  <= illegal_p0 ? '0 : alu_result;
          rsp_id    <= id_p0;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= accept ? S_ISSUE : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Request acceptance: operands go straight to the ALU registers.
      if (accept) begin
        alu_a      <= req_a[XLEN*grant_id +: XLEN];
        alu_b      <= req_b[XLEN*grant_id +: XLEN];
        alu_sel    <= sel_dec;
        illegal_p0 <= illegal_dec;
        id_p0      <= grant_id;
      end
    end
  end

endmodule

// File: tb/tb_riscv_alu_arbiter.sv
// Directed bench for riscv_alu_arbiter with a behavioural registered ALU
// attached to the alu_* ports.
module tb_riscv_alu_arbiter;
  import riscv_alu_pkg::*;

  localparam int NREQ = 2;
  localparam int XLEN = 32;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [4*NREQ-1:0]       req_op;
  logic [XLEN*NREQ-1:0]    req_a;
  logic [XLEN*NREQ-1:0]    req_b;
  logic [XLEN-1:0]         alu_a;
  logic [XLEN-1:0]         alu_b;
  logic [ALU_SEL_W-1:0]    alu_sel;
  logic [XLEN-1:0]         alu_result;
  logic                    rsp_valid;
  logic [$clog2(NREQ)-1:0] rsp_id;
  logic [XLEN-1:0]         rsp_data;
  logic                    rsp_ready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  riscv_alu_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_ready  (rsp_ready)
  );

  // Registered ALU stub; no strobe yields a poison value the arbiter must mask.
  always_ff @(posedge clk) begin
    case (alu_sel)
      10'b00_0000_0001: alu_result <= alu_a + alu_b;
      10'b00_0000_0010: alu_result <= alu_a - alu_b;
      10'b00_0000_0100: alu_result <= alu_a | alu_b;
      10'b00_0000_1000: alu_result <= alu_a ^ alu_b;
      10'b00_0001_0000: alu_result <= alu_a & alu_b;
      10'b00_0010_0000: alu_result <= alu_a << alu_b[4:0];
      10'b00_0100_0000: alu_result <= alu_a >> alu_b[4:0];
      10'b00_1000_0000: alu_result <= $unsigned($signed(alu_a) >>> alu_b[4:0]);
      10'b01_0000_0000: alu_result <= {31'd0, alu_a < alu_b};
      10'b10_0000_0000: alu_result <= {31'd0, $signed(alu_a) < $signed(alu_b)};
      default:          alu_result <= 32'hDEAD_BEEF;
    endcase
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[4*i +: 4]       = op;
    req_a[XLEN*i +: XLEN]  = a;
    req_b[XLEN*i +: XLEN]  = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  nrsp;
    logic r1_seen;
    logic [0:0] exp_id;

    rst       = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    set_req(0, ALU_OP_ADD, 32'd5, 32'd7);
    req_valid = 2'b11;

    // Reset values, with requests asserted to show req_ready is gated
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_id",    rsp_id,    0);
    check_eq("rst_rsp_data",  rsp_data,  0);
    check_eq("rst_alu_a",     alu_a,     0);
    check_eq("rst_alu_b",     alu_b,     0);
    check_eq("rst_alu_sel",   alu_sel,   0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b1;

    // Single ADD 5+7 on requester 0
    @(negedge clk);
    req_valid = 2'b01;
    #1 check_eq("t1_req_ready", req_ready, 2'b01);
    @(negedge clk);
    req_valid = '0;
    #1;
    check_eq("t1_issue_sel",   alu_sel,   10'b1);
    check_eq("t1_issue_a",     alu_a,     5);
    check_eq("t1_issue_b",     alu_b,     7);
    check_eq("t1_issue_valid", rsp_valid, 0);
    @(negedge clk);
    #1;
    check_eq("t1_wait_sel",    alu_sel,   10'b1);
    check_eq("t1_wait_valid",  rsp_valid, 0);
    @(negedge clk);
    #1;
    check_eq("t1_rsp_valid",   rsp_valid, 1);
    check_eq("t1_rsp_id",      rsp_id,    0);
    check_eq("t1_rsp_data",    rsp_data,  12);
    check_eq("t1_rsp_sel",     alu_sel,   0);
    rsp_ready = 1'b1;
    @(negedge clk);
    #1 check_eq("t1_done_valid", rsp_valid, 0);

    // Both requesters valid continuously, response always accepted
    set_req(0, ALU_OP_ADD, 32'd1, 32'd2);
    set_req(1, ALU_OP_SUB, 32'd9, 32'd4);
    req_valid = 2'b11;
    #1 check_eq("t2_first_grant", req_ready, 2'b01);
    nrsp    = 0;
    r1_seen = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      #1;
      if (req_ready[1]) r1_seen = 1'b1;
      check_eq("t2_cadence", rsp_valid, (c % 3 == 0));
      if (rsp_valid) begin
`ifdef RISCV_ALU_ARB_RR_EN
        exp_id = nrsp[0];
`else
        exp_id = 1'b0;
`endif
        check_eq("t2_rsp_id",   rsp_id,   exp_id);
        check_eq("t2_rsp_data", rsp_data, exp_id ? 64'd5 : 64'd3);
        nrsp++;
      end
    end
    check_eq("t2_rsp_count", nrsp, 4);
`ifndef RISCV_ALU_ARB_RR_EN
    check_eq("t2_req1_starved", r1_seen, 0);
`endif
    req_valid = '0;
    @(negedge clk);
    #1 check_eq("t2_idle_valid", rsp_valid, 0);

    // Back-pressure in RESP, then same-cycle grant of a pending SUB
    rsp_ready = 1'b0;
    set_req(0, ALU_OP_OR, 32'hF0, 32'h0F);
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b10;
    set_req(1, ALU_OP_SUB, 32'd3, 32'd5);
    @(negedge clk);
    #1 check_eq("t3_wait_ready", req_ready, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      check_eq("t3_hold_valid", rsp_valid, 1);
      check_eq("t3_hold_id",    rsp_id,    0);
      check_eq("t3_hold_data",  rsp_data,  32'hFF);
      check_eq("t3_hold_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    #1 check_eq("t4_same_cycle_grant", req_ready, 2'b10);
    @(negedge clk);
    req_valid = '0;
    #1;
    check_eq("t4_issue_valid", rsp_valid, 0);
    check_eq("t4_issue_a",     alu_a,     3);
    check_eq("t4_issue_sel",   alu_sel,   10'b10);
    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("t4_rsp_valid", rsp_valid, 1);
    check_eq("t4_rsp_id",    rsp_id,    1);
    check_eq("t4_rsp_data",  rsp_data,  32'hFFFF_FFFE);
    @(negedge clk);
    #1 check_eq("t4_done_valid", rsp_valid, 0);

    // Illegal op code 12
    set_req(0, 4'd12, 32'd1, 32'd2);
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = '0;
    #1 check_eq("t5_issue_sel", alu_sel, 0);
    @(negedge clk);
    #1 check_eq("t5_wait_sel", alu_sel, 0);
    @(negedge clk);
    #1;
    check_eq("t5_rsp_valid", rsp_valid, 1);
    check_eq("t5_rsp_data",  rsp_data,  0);
    @(negedge clk);

    // Reset during WAIT, then a fresh XOR
    set_req(0, ALU_OP_ADD, 32'd1, 32'd1);
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1 check_eq("t6_wait_sel", alu_sel, 10'b1);
    rst = 1'b0;
    set_req(0, ALU_OP_XOR, 32'hF0, 32'hFF);
    req_valid = 2'b01;
    #1;
    check_eq("t6_rst_sel",   alu_sel,   0);
    check_eq("t6_rst_valid", rsp_valid, 0);
    check_eq("t6_rst_ready", req_ready, 0);
    check_eq("t6_rst_a",     alu_a,     0);
    @(negedge clk);
    rst = 1'b1;
    #1 check_eq("t6_post_ready", req_ready, 2'b01);
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("t6_rsp_valid", rsp_valid, 1);
    check_eq("t6_rsp_id",    rsp_id,    0);
    check_eq("t6_rsp_data",  rsp_data,  32'h0F);

    // Reset while a response is held in RESP
    rst = 1'b0;
    #1;
    check_eq("t7_rst_valid", rsp_valid, 0);
    check_eq("t7_rst_data",  rsp_data,  0);
    @(negedge clk);
    rst = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    #1 check_eq("t7_idle_valid", rsp_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_alu_arbiter.md
# riscv_alu_arbiter

Shares the single registered-output integer ALU (`riscv_alu`) between NREQ requesters, e.g. the execute stage and the load/store address generator. It arbitrates with a valid/ready handshake and latches the winner's operands. It decodes the op into the ALU's one-hot `is_*` strobes, waits out the ALU's one-cycle registered latency, and returns the result with the requester's ID on a valid/ready response channel.

## Interface
- NREQ, 2 — number of requesters (2..4)
- XLEN, 32 — operand/result width
- clk  in  1  — clock, all state on rising edge
- rst  in  1  — asynchronous, active-low reset
- req_valid  in  NREQ  — per-requester request valid
- req_ready  out  NREQ  — per-requester accept; at most one bit high
- req_op  in  4*NREQ  — op code per requester, slice i = [4i+3:4i], codes from package
- req_a  in  XLEN*NREQ  — operand A per requester
- req_b  in  XLEN*NREQ  — operand B per requester
- alu_a  out  XLEN  — to ALU `alu_a`
- alu_b  out  XLEN  — to ALU `alu_b`
- alu_sel  out  10  — one-hot strobes to ALU: add, sub, or, xor, and, sll, srl, sra, sltu, slt
- alu_result  in  XLEN  — from ALU `alu_p_o`
- rsp_valid  out  1  — response valid
- rsp_id  out  $clog2(NREQ)  — index of requester owning response
- rsp_data  out  XLEN  — result
- rsp_ready  in  1  — response consumer accept

## Operation
- FSM: IDLE, ISSUE, WAIT, RESP.
- IDLE: grant one requester with req_valid high; req_ready[g] = 1 combinationally for that requester only. On acceptance (valid & ready) latch op, a, b, and ID; go to ISSUE.
- ISSUE: drive alu_a/alu_b from latches; alu_sel = decoded op. The ALU samples at the closing edge. Go to WAIT.
- WAIT: operands and alu_sel held. At the closing edge capture alu_result into rsp_data; go to RESP.
- RESP: rsp_valid = 1; rsp_id and rsp_data stable until rsp_ready.
  - On rsp_ready with any req_valid pending, grant and accept in the same cycle and go to ISSUE; no bubble through IDLE.
  - Otherwise go to IDLE.
- Outside ISSUE/WAIT, alu_sel = 0; alu_a/alu_b hold their last values.
- Op codes 0..9 map to the alu_sel bits in the order listed. Codes 10..15 are illegal:
  - alu_sel stays 0 and rsp_data = 0, not the ALU's X output.
  - The transaction still completes with normal timing.
- Shift amount: the arbiter passes alu_b unmodified; the requester masks it to [4:0].
- Requesters hold req_valid/op/a/b stable until accepted. Dropping valid before acceptance is allowed; nothing is latched.

## Timing
- Reset values: req_ready 0, rsp_valid 0, rsp_id 0, rsp_data 0, alu_a 0, alu_b 0, alu_sel 0, FSM IDLE, priority pointer 0.
- Latency: acceptance at edge N; rsp_valid high in cycle N+3.
- Throughput: one op per 3 cycles when rsp_ready is tied high.
- Back-pressure: RESP holds indefinitely; no new request is accepted while rsp_valid && !rsp_ready.
- Simultaneous requests: exactly one grant per accept cycle (see Configuration).
- Reset mid-operation: asynchronous return to IDLE. Any in-flight transaction is discarded and rsp_valid drops immediately.

## Configuration
- RISCV_ALU_ARB_RR_EN defined: round-robin arbitration.
  - Search starts at (last_granted+1) mod NREQ.
  - The pointer updates on each acceptance.
- RISCV_ALU_ARB_RR_EN undefined: fixed priority; lowest index wins; no pointer register.

## Structure
- Package `riscv_alu_pkg`:
  - 4-bit op code constants ALU_OP_ADD=0, SUB=1, OR=2, XOR=3, AND=4, SLL=5, SRL=6, SRA=7, SLTU=8, SLT=9.
  - ALU_SEL_W=10.
  - FSM state typedef.
- Sub-module `riscv_alu_op_decode`: combinational op code to alu_sel one-hot, plus an illegal flag. It is reused by the decode stage.

## Test plan
- Req0 only: ADD a=5, b=7 accepted at cycle 0 → rsp_valid cycle 3, rsp_id 0, rsp_data 12; alu_sel = add bit only during ISSUE/WAIT.
- Both valid every cycle, rsp_ready=1:
  - With RR_EN: grants alternate 0,1,0,1.
  - Without RR_EN: requester 0 always granted and req_ready[1] never high.
- rsp_ready held low 5 cycles in RESP → rsp_valid, rsp_id, rsp_data stable throughout; req_ready all 0; completes on rsp_ready.
- RESP with rsp_ready=1 and req1 SUB a=3, b=5 pending → accepted same cycle; next response 0xFFFFFFFE at 3 cycles later.
- Illegal op 12 → alu_sel 0 throughout; rsp_data 0 at cycle 3.
- rst asserted during WAIT → rsp_valid, req_ready, alu_sel go to 0 immediately; after release, a fresh XOR 0xF0 ^ 0xFF returns 0x0F.
